// File: rtl/axi_lite_bram_slave.sv
// rtl/axi_lite_bram_slave.sv - AXI4-Lite slave in front of a single-port-style word memory
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_READ/R_DATA) engines share one array.
module axi_lite_bram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ADDR_WIDTH  = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int                    IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   SPAN  = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DATA
    } r_state_e;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};
    logic [31:0] mem_rd_q;

    w_state_e    w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_en;

    r_state_e    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        ar_ok_q, ar_ok_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_en;

    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic                  aw_in_range, ar_in_range;
    logic [IDX_W-1:0]      aw_idx, ar_idx;

    // Offset compare is one bit wider so BASE + span cannot wrap the address space.
    assign aw_off      = AWADDR - BASE;
    assign ar_off      = ARADDR - BASE;
    assign aw_in_range = (AWADDR >= BASE) && ({1'b0, aw_off} < SPAN);
    assign ar_in_range = (ARADDR >= BASE) && ({1'b0, ar_off} < SPAN);
    assign aw_idx      = aw_off[IDX_W+1:2];
    assign ar_idx      = ar_off[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q) begin
                    if (AWVALID && WVALID) begin
                        wr_en     = aw_in_range && !ARESET;
                        bvalid_d  = 1'b1;
                        bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
                        w_state_d = W_RESP;
                    end
                end else if (AWVALID && WVALID) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // The array is read on the AR handshake itself, so a write committing on the
    // same edge is not yet visible (read-first).
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        ar_ok_d   = ar_ok_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q) begin
                    if (ARVALID) begin
                        rd_en     = !ARESET;
                        ar_ok_d   = ar_in_range;
                        r_state_d = R_READ;
                    end
                end else if (ARVALID) begin
                    arready_d = 1'b1;
                end
            end
            R_READ: begin
                rvalid_d  = 1'b1;
                rdata_d   = ar_ok_q ? mem_rd_q : 32'h0;
                rresp_d   = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            ar_ok_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            ar_ok_q   <= ar_ok_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && WSTRB[b]) begin
                mem_q[aw_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
        if (rd_en) begin
            mem_rd_q <= mem_q[ar_idx];
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// tb/tb_axi_lite_bram_slave.sv - randomized scoreboard bench for axi_lite_bram_slave
module tb_axi_lite_bram_slave;

    localparam logic [31:0] BASE  = 32'hA000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] SPAN  = 32'd4096;

    logic        ACLK, ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi_lite_bram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .AWADDR (AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] model [DEPTH];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] a);
        if (in_rng(a)) return {2'b00, model[widx(a)]};
        return {2'b10, 32'h0};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
    endtask

    // Monitor: response scoreboard, hold stability, latency and ready exclusion.
    initial begin
        logic       bv_p = 1'b0, br_p = 1'b0, rv_p = 1'b0, rr_p = 1'b0, rst_p = 1'b1;
        logic [1:0] bresp_p = 2'b00, rresp_p = 2'b00;
        logic [31:0] rdata_p = 32'h0;
        int         aw_hs = -10, ar_hs = -10;
        forever begin
            @(negedge ACLK);
            if (!rst_p) begin
                if (bv_p && !br_p)
                    chk("b_hold", 64'({BVALID, BRESP}), 64'({1'b1, bresp_p}));
                if (rv_p && !rr_p)
                    chk("r_hold", 64'({RVALID, RRESP, RDATA}), 64'({1'b1, rresp_p, rdata_p}));
                if (cyc == aw_hs + 1) chk("b_latency", 64'(BVALID), 64'(1'b1));
                if (cyc == ar_hs + 1) chk("r_early", 64'(RVALID), 64'(1'b0));
                if (cyc == ar_hs + 2) chk("r_latency", 64'(RVALID), 64'(1'b1));
            end
            if (BVALID) chk("awready_in_resp", 64'({AWREADY, WREADY}), 64'(2'b00));
            if (RVALID) chk("arready_in_data", 64'(ARREADY), 64'(1'b0));
            if (!ARESET) begin
                if (AWVALID && AWREADY && WVALID && WREADY) aw_hs = cyc;
                if (ARVALID && ARREADY) ar_hs = cyc;
                if (BVALID && BREADY) begin
                    if (b_q.size() == 0) chk("b_unexpected", 64'(1'b1), 64'(1'b0));
                    else chk("bresp", 64'(BRESP), 64'(b_q.pop_front()));
                end
                if (RVALID && RREADY) begin
                    if (r_q.size() == 0) chk("r_unexpected", 64'(1'b1), 64'(1'b0));
                    else chk("rdata_rresp", 64'({RRESP, RDATA}), 64'(r_q.pop_front()));
                end
            end
            bv_p = BVALID; br_p = BREADY; bresp_p = BRESP;
            rv_p = RVALID; rr_p = RREADY; rresp_p = RRESP; rdata_p = RDATA;
            rst_p = ARESET;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay, input bit probe);
        bit ok = 1'b0;
        @(posedge ACLK); #1;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (AWREADY && WREADY) begin ok = 1'b1; break; end
        end
        if (!ok) chk("write_hs_timeout", 64'(1'b0), 64'(1'b1));
        else model_write(a, d, s);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge ACLK);
                if (BVALID) begin ok = 1'b1; break; end
            end
            if (!ok) chk("bvalid_timeout", 64'(1'b0), 64'(1'b1));
            if (probe) begin @(posedge ACLK); #1; AWVALID = 1'b1; WVALID = 1'b1; end
            repeat (bdelay) @(negedge ACLK);
            @(posedge ACLK); #1;
            BREADY = 1'b1; AWVALID = 1'b0; WVALID = 1'b0;
            @(negedge ACLK);
            @(posedge ACLK); #1;
            BREADY = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay);
        bit ok = 1'b0;
        @(posedge ACLK); #1;
        ARADDR = a; ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) chk("read_hs_timeout", 64'(1'b0), 64'(1'b1));
        else r_q.push_back(exp_read(a));
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge ACLK);
                if (RVALID) begin ok = 1'b1; break; end
            end
            if (!ok) chk("rvalid_timeout", 64'(1'b0), 64'(1'b1));
            repeat (rdelay) @(negedge ACLK);
            @(posedge ACLK); #1;
            RREADY = 1'b1;
            @(negedge ACLK);
            @(posedge ACLK); #1;
            RREADY = 1'b0;
        end
    endtask

    // Write and read of the same word presented together so both handshakes share a cycle.
    task automatic do_conc(input logic [31:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        @(posedge ACLK); #1;
        AWADDR = a; WDATA = d; WSTRB = 4'hF; ARADDR = a;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (AWREADY || ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) chk("conc_hs_timeout", 64'(1'b0), 64'(1'b1));
        else begin
            chk("conc_same_cycle", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
            r_q.push_back(exp_read(a));
            model_write(a, d, 4'hF);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel = int'($urandom_range(0, 9));
        if (sel < 5) return BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        if (sel < 8) return BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
        if (sel == 8) return BASE + SPAN + ($urandom_range(0, 255) << 2);
        return BASE - ($urandom_range(1, 64) << 2);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        ARESET = 1'b1;
        AWADDR = '0; WDATA = '0; WSTRB = '0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_outputs", 64'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}), 64'(0));
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        do_write(32'hA000_0000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        do_read(32'hA000_0000, 0);

        do_write(32'hA000_0004, 32'h1122_3344, 4'hF, 1, 1'b0);
        do_write(32'hA000_0004, 32'h0000_AA00, 4'b0010, 0, 1'b0);
        do_read(32'hA000_0004, 0);
        do_write(32'hA000_0004, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
        do_read(32'hA000_0006, 1);

        do_write(32'hA000_1000, 32'h9999_9999, 4'hF, 0, 1'b0);
        do_read(32'hA000_1000, 0);
        do_read(32'hA000_0000, 0);
        do_write(32'hA000_0FFC, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
        do_read(32'hA000_0FFC, 0);
        do_read(32'h9FFF_FFFC, 0);

        do_write(32'hA000_000C, 32'h7777_1234, 4'hF, 5, 1'b1);
        do_read(32'hA000_000C, 5);

        @(posedge ACLK); #1;
        AWADDR = BASE; AWVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk("aw_only_no_ready", 64'({AWREADY, WREADY}), 64'(2'b00));
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("w_only_no_ready", 64'({AWREADY, WREADY}), 64'(2'b00));
        end
        @(posedge ACLK); #1;
        WVALID = 1'b0;

        do_conc(32'hA000_0008, 32'hCAFE_F00D);
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (4) @(posedge ACLK);
        #1;
        BREADY = 1'b0; RREADY = 1'b0;
        do_read(32'hA000_0008, 0);

        do_conc(32'hA000_0010, 32'h5A5A_5A5A);
        @(negedge ACLK);
        @(negedge ACLK);
        chk("pre_reset_valids", 64'({BVALID, RVALID}), 64'(2'b11));
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("after_reset_outputs", 64'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}), 64'(0));
        b_q.delete();
        r_q.delete();
        do_read(32'hA000_0000, 0);
        do_read(32'hA000_0010, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), 1'b0);
            else
                do_read(rand_addr(), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge ACLK);
        chk("b_queue_drained", 64'(b_q.size()), 64'(0));
        chk("r_queue_drained", 64'(r_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
